// File: rtl/bsg_link_ddr_pkg.sv
// Shared definitions for the DDR link receive path: parameter defaults,
// derived-width helpers and the beat-assembly phase type.
package bsg_link_ddr_pkg;

  localparam int channel_width_gp         = 8;
  localparam int num_channels_gp          = 2;
  localparam int lg_fifo_depth_gp         = 6;
  localparam int lg_credit_decimation_gp  = 3;

  // One beat carries both DDR edges of every channel.
  function automatic int beat_width(input int channel_width, input int num_channels);
    return 2 * channel_width * num_channels;
  endfunction

  // A core word is two consecutive beats.
  function automatic int core_width(input int channel_width, input int num_channels);
    return 2 * beat_width(channel_width, num_channels);
  endfunction

  typedef enum logic {PH0 = 1'b0, PH1 = 1'b1} phase_e;

endpackage

// File: rtl/bsg_link_ddr_downstream_rx_if.sv
// Wire-side beat inputs, core-side valid/ready word port and credit/status
// outputs of the DDR downstream receiver, bundled with master/slave views.
interface bsg_link_ddr_downstream_rx_if
  import bsg_link_ddr_pkg::*;
#(
  parameter int channel_width_p = channel_width_gp,
  parameter int num_channels_p  = num_channels_gp
);
  localparam int bw_lp = beat_width(channel_width_p, num_channels_p);
  localparam int cw_lp = core_width(channel_width_p, num_channels_p);

  logic [num_channels_p-1:0] io_valid_i;
  logic [bw_lp-1:0]          io_data_i;
  logic                      core_valid_o;
  logic [cw_lp-1:0]          core_data_o;
  logic                      core_ready_i;
  logic [num_channels_p-1:0] token_clk_o;
  logic                      overflow_o;
  logic                      skew_err_o;

  // Receiver side
  modport master (
    input  io_valid_i, io_data_i, core_ready_i,
    output core_valid_o, core_data_o, token_clk_o, overflow_o, skew_err_o
  );

  // Link/core environment side
  modport slave (
    output io_valid_i, io_data_i, core_ready_i,
    input  core_valid_o, core_data_o, token_clk_o, overflow_o, skew_err_o
  );

endinterface

// File: rtl/bsg_link_rx_fifo.sv
// Show-ahead FIFO sized to the sender's credit pool; a write into a full
// FIFO is legal only on the same edge as a read.
module bsg_link_rx_fifo #(
  parameter int width_p    = 64,
  parameter int lg_depth_p = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_v_i,
  input  logic [width_p-1:0]  enq_data_i,
  input  logic                deq_ready_i,
  output logic                valid_o,
  output logic [width_p-1:0]  data_o,
  output logic [lg_depth_p:0] count_o,
  output logic                full_o
);
  localparam logic [lg_depth_p:0] full_count_lp = {1'b1, {lg_depth_p{1'b0}}};

  logic [width_p-1:0]    mem_q [2**lg_depth_p];
  logic [lg_depth_p-1:0] wr_ptr_q, wr_ptr_d;
  logic [lg_depth_p-1:0] rd_ptr_q, rd_ptr_d;
  logic [lg_depth_p:0]   count_q, count_d;
  logic                  deq_s;

  assign valid_o = (count_q != {(lg_depth_p+1){1'b0}});
  assign full_o  = (count_q == full_count_lp);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign deq_s   = deq_ready_i & valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_v_i) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq_v_i, deq_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (enq_v_i) begin
      mem_q[wr_ptr_q] <= enq_data_i;
    end
  end

endmodule

// File: rtl/bsg_link_ddr_downstream_rx.sv
// DDR link receiver: pairs wire beats into core words, buffers them, and
// returns one credit token toggle per 2^lg_credit_decimation_p dequeues.
module bsg_link_ddr_downstream_rx
  import bsg_link_ddr_pkg::*;
#(
  parameter int channel_width_p        = channel_width_gp,
  parameter int num_channels_p         = num_channels_gp,
  parameter int lg_fifo_depth_p        = lg_fifo_depth_gp,
  parameter int lg_credit_decimation_p = lg_credit_decimation_gp
) (
  input  logic clk,
  input  logic rst,
  bsg_link_ddr_downstream_rx_if.master link
);
  localparam int bw_lp = beat_width(channel_width_p, num_channels_p);
  localparam int cw_lp = core_width(channel_width_p, num_channels_p);

  phase_e                            phase_q, phase_d;
  logic [bw_lp-1:0]                  lo_q, lo_d;
  logic [lg_credit_decimation_p-1:0] credit_q, credit_d;
  logic [num_channels_p-1:0]         token_q, token_d;
  logic                              overflow_q, overflow_d;
  logic                              skew_q, skew_d;

  logic                 beat_v_s, word_v_s, enq_fire_s, deq_fire_s;
  logic                 fifo_valid_s, fifo_full_s;
  logic [cw_lp-1:0]     fifo_data_s;
  logic [lg_fifo_depth_p:0] fifo_count_s;

  assign beat_v_s   = &link.io_valid_i;
  assign deq_fire_s = fifo_valid_s & link.core_ready_i;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign enq_fire_s = word_v_s & (~fifo_full_s | deq_fire_s);

  always_comb begin
    phase_d    = phase_q;
    lo_d       = lo_q;
    word_v_s   = 1'b0;
    credit_d   = credit_q;
    token_d    = token_q;
    overflow_d = overflow_q;
    skew_d     = skew_q;
    case (phase_q)
      PH0: begin
        if (beat_v_s) begin
          lo_d    = link.io_data_i;
          phase_d = PH1;
        end else begin
          phase_d = PH0;
        end
      end
      PH1: begin
        if (beat_v_s) begin
          word_v_s = 1'b1;
          phase_d  = PH0;
        end else begin
          phase_d = PH1;
        end
      end
      default: phase_d = PH0;
    endcase
    if (word_v_s & ~enq_fire_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    if ((|link.io_valid_i) & ~beat_v_s) begin
      skew_d = 1'b1;
    end else begin
      skew_d = skew_q;
    end
    // Token lines flip together when the decimation counter wraps.
    if (deq_fire_s) begin
      credit_d = credit_q + 1'b1;
      if (credit_q == {lg_credit_decimation_p{1'b1}}) begin
        token_d = ~token_q;
      end else begin
        token_d = token_q;
      end
    end else begin
      credit_d = credit_q;
      token_d  = token_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH0;
      lo_q       <= '0;
      credit_q   <= '0;
      token_q    <= '0;
      overflow_q <= 1'b0;
      skew_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      lo_q       <= lo_d;
      credit_q   <= credit_d;
      token_q    <= token_d;
      overflow_q <= overflow_d;
      skew_q     <= skew_d;
    end
  end

  bsg_link_rx_fifo #(
    .width_p    (cw_lp),
    .lg_depth_p (lg_fifo_depth_p)
  ) fifo (
    .clk         (clk),
    .rst         (rst),
    .enq_v_i     (enq_fire_s),
    .enq_data_i  ({link.io_data_i, lo_q}),
    .deq_ready_i (link.core_ready_i),
    .valid_o     (fifo_valid_s),
    .data_o      (fifo_data_s),
    .count_o     (fifo_count_s),
    .full_o      (fifo_full_s)
  );

  assign link.core_valid_o = fifo_valid_s;
  assign link.core_data_o  = fifo_data_s;
  assign link.token_clk_o  = token_q;
  assign link.overflow_o   = overflow_q;
  assign link.skew_err_o   = skew_q;

  logic unused_s;
  assign unused_s = ^fifo_count_s;

endmodule

// File: tb/tb_bsg_link_ddr_downstream_rx.sv
// Directed plus randomized stimulus for the DDR downstream receiver, checked
// every cycle against a queue-based model of the word stream and credits.
module tb_bsg_link_ddr_downstream_rx;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  bsg_link_ddr_downstream_rx_if bus ();

  bsg_link_ddr_downstream_rx dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what the receiver must hold, described as a word queue.
  logic [63:0] m_q[$];
  bit          m_ph;
  logic [31:0] m_lo;
  int          m_deqs;
  logic [1:0]  m_tok;
  bit          m_ovf, m_skew;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ph = 1'b0; m_lo = '0; m_deqs = 0; m_tok = 2'b00; m_ovf = 1'b0; m_skew = 1'b0;
    end else begin
      if (m_q.size() != 0 && bus.core_ready_i) begin
        void'(m_q.pop_front());
        m_deqs++;
        if (m_deqs % 8 == 0) m_tok = ~m_tok;
      end
      if (bus.io_valid_i == 2'b11) begin
        if (!m_ph) begin
          m_lo = bus.io_data_i;
          m_ph = 1'b1;
        end else begin
          m_ph = 1'b0;
          if (m_q.size() < 64) m_q.push_back({bus.io_data_i, m_lo});
          else m_ovf = 1'b1;
        end
      end else if (bus.io_valid_i != 2'b00) begin
        m_skew = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", {63'd0, bus.core_valid_o}, {63'd0, m_q.size() != 0});
      if (m_q.size() != 0) chk("data", bus.core_data_o, m_q[0]);
      chk("token", {62'd0, bus.token_clk_o}, {62'd0, m_tok});
      chk("overflow", {63'd0, bus.overflow_o}, {63'd0, m_ovf});
      chk("skew", {63'd0, bus.skew_err_o}, {63'd0, m_skew});
    end
  end

  task automatic drive(input logic [1:0] v, input logic [31:0] d, input logic r);
    bus.io_valid_i   = v;
    bus.io_data_i    = d;
    bus.core_ready_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    drive(2'b00, 32'd0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, lo, hi;
    int n;
    rst = 1'b1;
    drive(2'b00, 32'd0, 1'b0);
    drive(2'b00, 32'd0, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", {63'd0, bus.core_valid_o}, 64'd0);
    chk("rst_token", {62'd0, bus.token_clk_o}, 64'd0);
    chk("rst_overflow", {63'd0, bus.overflow_o}, 64'd0);
    chk("rst_skew", {63'd0, bus.skew_err_o}, 64'd0);

    // Single word, consumed immediately
    drive(2'b11, 32'h33221100, 1'b1);
    drive(2'b11, 32'h77665544, 1'b1);
    chk("single_valid", {63'd0, bus.core_valid_o}, 64'd1);
    chk("single_data", bus.core_data_o, 64'h7766554433221100);
    drive(2'b00, 32'd0, 1'b1);
    chk("single_one_cycle", {63'd0, bus.core_valid_o}, 64'd0);

    // Gapped beats
    drive(2'b11, 32'hA5A5_0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("gap_no_valid", {63'd0, bus.core_valid_o}, 64'd0);
      drive(2'b00, 32'hDEAD_BEEF, 1'b1);
    end
    chk("gap_no_valid", {63'd0, bus.core_valid_o}, 64'd0);
    drive(2'b11, 32'h5A5A_0002, 1'b1);
    chk("gap_data", bus.core_data_o, 64'h5A5A_0002_A5A5_0001);
    drive(2'b00, 32'd0, 1'b1);

    // Credits: 16 words, token flips after the 8th and 16th dequeue
    pulse_rst();
    for (int k = 1; k <= 16; k++) begin
      drive(2'b11, $urandom, 1'b1);
      drive(2'b11, $urandom, 1'b1);
      drive(2'b00, 32'd0, 1'b1);
      chk("credit_token", {62'd0, bus.token_clk_o}, (k >= 8 && k < 16) ? 64'd3 : 64'd0);
    end

    // Fill to 64, then one more word is dropped
    for (int k = 1; k <= 65; k++) begin
      drive(2'b11, $urandom, 1'b0);
      drive(2'b11, $urandom, 1'b0);
      if (k == 64) chk("full_no_ovf", {63'd0, bus.overflow_o}, 64'd0);
    end
    chk("overflow_set", {63'd0, bus.overflow_o}, 64'd1);
    lo = $urandom; hi = $urandom;
    drive(2'b11, lo, 1'b0);
    drive(2'b11, hi, 1'b1);
    chk("overflow_sticky", {63'd0, bus.overflow_o}, 64'd1);
    n = 0;
    for (int t = 0; t < 100 && bus.core_valid_o; t++) begin
      n++;
      if (n == 64) chk("full_last_word", bus.core_data_o, {hi, lo});
      drive(2'b00, 32'd0, 1'b1);
    end
    chk("drain_count", n, 64'd64);

    // Skew: partial valid is discarded and leaves the phase alone
    pulse_rst();
    a = $urandom; b = $urandom;
    drive(2'b11, a, 1'b1);
    drive(2'b01, 32'hFFFF_FFFF, 1'b1);
    chk("skew_set", {63'd0, bus.skew_err_o}, 64'd1);
    chk("skew_no_enq", {63'd0, bus.core_valid_o}, 64'd0);
    drive(2'b11, b, 1'b1);
    chk("skew_word", bus.core_data_o, {b, a});
    drive(2'b00, 32'd0, 1'b1);

    // Reset mid-word
    drive(2'b11, 32'h0BAD_0BAD, 1'b1);
    pulse_rst();
    chk("rstmid_valid", {63'd0, bus.core_valid_o}, 64'd0);
    chk("rstmid_token", {62'd0, bus.token_clk_o}, 64'd0);
    a = $urandom; b = $urandom;
    drive(2'b11, a, 1'b1);
    drive(2'b11, b, 1'b1);
    chk("rstmid_word", bus.core_data_o, {b, a});
    drive(2'b00, 32'd0, 1'b1);

    // Randomized traffic with stalls, skew and occasional reset
    for (int i = 0; i < 1200; i++) begin
      int r;
      logic [1:0] v;
      logic rdy;
      r = $urandom_range(0, 99);
      v = (r < 60) ? 2'b11 : (r < 63) ? 2'($urandom_range(1, 2)) : 2'b00;
      rdy = ((i % 300) < 160) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      drive(v, $urandom, rdy);
      rst = 1'b0;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
